// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle between the stopwatch digit source and the seven-segment scan driver.
interface seg7_scan_driver_if;
    logic       scan_tick;
    logic       blink_tick;
    logic       adj_en;
    logic       adj_sel;
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       frame_done;

    modport master (
        output scan_tick, blink_tick, adj_en, adj_sel, mt, mo, st, so,
        input  seg, an, dp, frame_done
    );

    modport slave (
        input  scan_tick, blink_tick, adj_en, adj_sel, mt, mo, st, so,
        output seg, an, dp, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 4-digit seven-segment driver with dead-time, frame snapshot and field blink.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to darken idx3 when the captured minutes-tens digit is 0.
module seg7_scan_driver #(
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned DP_DIGIT     = 2
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int unsigned    CNT_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [1:0]     DP_IDX   = 2'(DP_DIGIT);
    localparam logic [6:0]     SEG_OFF  = 7'b1111111;
    localparam logic [3:0]     AN_OFF   = 4'b1111;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             phase_q, phase_d;
    logic [15:0]      snap_q, snap_d;
    logic             first_q, first_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             fd_q, fd_d;
    logic [3:0]       digit;
    logic             field_blank;

    // Active-low gfedcba pattern; non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= 2'd3;
            phase_q <= 1'b0;
            snap_q  <= '0;
            first_q <= 1'b1;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            snap_q  <= snap_d;
            first_q <= first_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
        end
    end

    // Outputs are registered from the post-edge state, so SHOW values appear on the edge entering SHOW.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        first_d     = first_q;
        fd_d        = 1'b0;
        phase_d     = bus.adj_en ? (phase_q ^ bus.blink_tick) : 1'b0;
        an_d        = AN_OFF;
        seg_d       = SEG_OFF;
        dp_d        = 1'b1;
        digit       = 4'd0;
        field_blank = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    if (idx_d == 2'd0) begin
                        snap_d  = {bus.mt, bus.mo, bus.st, bus.so};
                        fd_d    = ~first_q;
                        first_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (bus.scan_tick) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_BLANK;
        endcase

        // idx0 tracks the live seconds-ones; higher digits come from the frame snapshot.
        case (idx_d)
            2'd0:    digit = bus.so;
            2'd1:    digit = snap_d[7:4];
            2'd2:    digit = snap_d[11:8];
            default: digit = snap_d[15:12];
        endcase

        field_blank = phase_d & (bus.adj_sel ? ~idx_d[1] : idx_d[1]);

        if (state_d == ST_SHOW) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = field_blank ? SEG_OFF : decode(digit);
            dp_d  = (idx_d != DP_IDX);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if ((idx_d == 2'd3) && (snap_d[15:12] == 4'd0)) begin
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
            end
`else
`endif
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed vector table, corner sequences and random stimulus vs. a reference model.
module tb_seg7_scan_driver;

    localparam int BLANK = 2;
    localparam int DPD   = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .BLANK_CYCLES(BLANK),
        .DP_DIGIT    (DPD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference model: remaining dark cycles, digit on display, blink phase, captured frame.
    int         m_dark;
    int         m_dig;
    bit         m_phase;
    bit         m_first;
    bit         m_fd;
    logic [3:0] m_snap [4];

    always @(posedge clk) begin
        m_fd = 1'b0;
        if (!rst_n) begin
            m_dark  = BLANK;
            m_dig   = 3;
            m_phase = 1'b0;
            m_first = 1'b1;
            for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
        end else begin
            m_phase = bus.adj_en ? (m_phase ^ bus.blink_tick) : 1'b0;
            if (m_dark > 0) begin
                m_dark = m_dark - 1;
                if (m_dark == 0) begin
                    m_dig = (m_dig + 1) % 4;
                    if (m_dig == 0) begin
                        m_snap[0] = bus.so;
                        m_snap[1] = bus.st;
                        m_snap[2] = bus.mo;
                        m_snap[3] = bus.mt;
                        m_fd      = !m_first;
                        m_first   = 1'b0;
                    end
                end
            end else if (bus.scan_tick) begin
                m_dark = BLANK;
            end
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] p [10];
        p[0] = 7'b1000000; p[1] = 7'b1111001; p[2] = 7'b0100100; p[3] = 7'b0110000;
        p[4] = 7'b0011001; p[5] = 7'b0010010; p[6] = 7'b0000010; p[7] = 7'b1111000;
        p[8] = 7'b0000000; p[9] = 7'b0010000;
        if (v > 4'd9) return 7'b0111111;
        return p[v];
    endfunction

    function automatic void model_out(output logic [3:0] an, output logic [6:0] seg, output logic dp);
        logic [3:0] val;
        an  = 4'b1111;
        seg = 7'b1111111;
        dp  = 1'b1;
        if (m_dark == 0) begin
            val = (m_dig == 0) ? bus.so : m_snap[m_dig];
            an  = 4'(~(32'd1 << m_dig));
            seg = (m_phase && (bus.adj_sel ? (m_dig < 2) : (m_dig >= 2))) ? 7'b1111111 : seg_of(val);
            dp  = (m_dig == DPD) ? 1'b0 : 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (m_dig == 3 && m_snap[3] == 4'd0) begin
                an  = 4'b1111;
                seg = 7'b1111111;
            end
`endif
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        @(posedge clk);
        #1;
        model_out(ean, eseg, edp);
        check("model_an", 32'(bus.an), 32'(ean));
        check("model_seg", 32'(bus.seg), 32'(eseg));
        check("model_dp", 32'(bus.dp), 32'(edp));
        check("model_frame_done", 32'(bus.frame_done), 32'(m_fd));
    endtask

    task automatic set_digits(input logic [15:0] d);
        bus.mt = d[15:12];
        bus.mo = d[11:8];
        bus.st = d[7:4];
        bus.so = d[3:0];
    endtask

    // Leave the current digit and run until the model shows digit k.
    task automatic goto_digit(input int k);
        int n;
        n = 0;
        do begin
            bus.scan_tick = (m_dark == 0);
            tick();
            bus.scan_tick = 1'b0;
            n++;
        end while (!(m_dark == 0 && m_dig == k) && n < 64);
        if (n >= 64) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto_digit%0d timeout actual=dark%0d required=digit%0d", k, m_dark, k);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        scan;
        logic [15:0] dig;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic [15:0] d,
                                input logic [3:0] an, input logic [6:0] sg,
                                input logic dp, input logic fd);
        vec_t v;
        v.rst = r; v.scan = s; v.dig = d; v.an = an; v.seg = sg; v.dp = dp; v.fd = fd;
        vecs.push_back(v);
    endfunction

    localparam logic [15:0] D1 = 16'h1234;
    localparam logic [15:0] D5 = 16'h5234;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.scan_tick  = 1'b0;
        bus.blink_tick = 1'b0;
        bus.adj_en     = 1'b0;
        bus.adj_sel    = 1'b0;
        set_digits(D1);

        // Each row: inputs held during the cycle, expected outputs just after its closing edge.
        add(0, 0, D1, 4'hF, 7'h7F, 1, 0);
        add(0, 0, D1, 4'hF, 7'h7F, 1, 0);
        add(1, 0, D1, 4'hF, 7'h7F, 1, 0);
        add(1, 0, D1, 4'hE, 7'h19, 1, 0);
        add(1, 0, D1, 4'hE, 7'h19, 1, 0);
        add(1, 1, D1, 4'hF, 7'h7F, 1, 0);
        add(1, 0, D1, 4'hF, 7'h7F, 1, 0);
        add(1, 0, D1, 4'hD, 7'h30, 1, 0);
        add(1, 1, D1, 4'hF, 7'h7F, 1, 0);
        add(1, 0, D1, 4'hF, 7'h7F, 1, 0);
        add(1, 0, D1, 4'hB, 7'h24, 0, 0);
        add(1, 1, D1, 4'hF, 7'h7F, 1, 0);
        add(1, 0, D1, 4'hF, 7'h7F, 1, 0);
        add(1, 0, D1, 4'h7, 7'h79, 1, 0);
        add(1, 1, D1, 4'hF, 7'h7F, 1, 0);
        add(1, 0, D1, 4'hF, 7'h7F, 1, 0);
        add(1, 0, D1, 4'hE, 7'h19, 1, 1);
        add(1, 0, D5, 4'hE, 7'h19, 1, 0);
        for (int d = 1; d < 8; d++) begin
            add(1, 1, D5, 4'hF, 7'h7F, 1, 0);
            add(1, 0, D5, 4'hF, 7'h7F, 1, 0);
            case (d % 4)
                1: add(1, 0, D5, 4'hD, 7'h30, 1, 0);
                2: add(1, 0, D5, 4'hB, 7'h24, 0, 0);
                3: add(1, 0, D5, 4'h7, (d < 4) ? 7'h79 : 7'h12, 1, 0);
                default: add(1, 0, D5, 4'hE, 7'h19, 1, 1);
            endcase
        end

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst;
            bus.scan_tick = vecs[i].scan;
            set_digits(vecs[i].dig);
            tick();
            check($sformatf("vec%0d_an", i), 32'(bus.an), 32'(vecs[i].an));
            check($sformatf("vec%0d_seg", i), 32'(bus.seg), 32'(vecs[i].seg));
            check($sformatf("vec%0d_dp", i), 32'(bus.dp), 32'(vecs[i].dp));
            check($sformatf("vec%0d_fd", i), 32'(bus.frame_done), 32'(vecs[i].fd));
        end
        bus.scan_tick = 1'b0;

        // Blink of the seconds field.
        goto_digit(0);
        bus.adj_en = 1'b1; bus.adj_sel = 1'b1; bus.blink_tick = 1'b1;
        tick();
        bus.blink_tick = 1'b0;
        check("blink_idx0_seg", 32'(bus.seg), 32'h7F);
        check("blink_idx0_an", 32'(bus.an), 32'hE);
        goto_digit(1);
        check("blink_idx1_seg", 32'(bus.seg), 32'h7F);
        check("blink_idx1_an", 32'(bus.an), 32'hD);
        goto_digit(2);
        check("blink_idx2_seg", 32'(bus.seg), 32'h24);
        check("blink_idx2_dp", 32'(bus.dp), 32'h0);
        goto_digit(3);
        check("blink_idx3_seg", 32'(bus.seg), 32'h12);
        goto_digit(0);
        check("blink_idx0_again", 32'(bus.seg), 32'h7F);
        bus.blink_tick = 1'b1;
        tick();
        bus.blink_tick = 1'b0;
        check("blink_restore", 32'(bus.seg), 32'h19);
        bus.blink_tick = 1'b1;
        tick();
        bus.blink_tick = 1'b0;
        check("blink_reblank", 32'(bus.seg), 32'h7F);
        bus.adj_en = 1'b0;
        tick();
        check("blink_adj_off", 32'(bus.seg), 32'h19);

        // Non-BCD code on the live digit.
        set_digits(16'h523C);
        tick();
        check("invalid_bcd_seg", 32'(bus.seg), 32'h3F);

        // Leading zero in minutes tens.
        set_digits(16'h0234);
        goto_digit(0);
        goto_digit(3);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("lead_zero_an", 32'(bus.an), 32'hF);
        check("lead_zero_seg", 32'(bus.seg), 32'h7F);
`else
        check("lead_zero_an", 32'(bus.an), 32'h7);
        check("lead_zero_seg", 32'(bus.seg), 32'h40);
`endif

        // Reset while idx1 is shown.
        set_digits(D1);
        goto_digit(1);
        rst_n = 1'b0;
        tick();
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_seg", 32'(bus.seg), 32'h7F);
        check("rst_dp", 32'(bus.dp), 32'h1);
        check("rst_fd", 32'(bus.frame_done), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_rel_dark", 32'(bus.an), 32'hF);
        tick();
        check("rst_rel_show_an", 32'(bus.an), 32'hE);
        check("rst_rel_show_fd", 32'(bus.frame_done), 32'h0);

        // Random stimulus against the model.
        for (int c = 0; c < 4000; c++) begin
            rst_n          = ($urandom_range(0, 299) != 0);
            bus.scan_tick  = ($urandom_range(0, 2) == 0);
            bus.blink_tick = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 39) == 0) bus.adj_en = ~bus.adj_en;
            if ($urandom_range(0, 29) == 0) bus.adj_sel = ~bus.adj_sel;
            if ($urandom_range(0, 49) == 0) set_digits(16'($urandom));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the stopwatch BCD digits (minutes tens/ones, seconds tens/ones).
- Time-multiplexes the four digits onto a common-anode 4-digit seven-segment display.
- Inserts dead-time between digits to suppress ghosting and blinks the field being adjusted.
- Snapshots the digits once per frame so a count update never tears a displayed frame.

Parameters:
- BLANK_CYCLES, 4, clk cycles of all-off dead-time before each digit is shown; legal range >=1.
- DP_DIGIT, 2, digit index whose decimal point is lit as the minutes/seconds separator.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- scan_tick  in  1  one-cycle pulse from the clock divider fast tick; ends current digit
- blink_tick  in  1  one-cycle pulse; toggles blink phase
- adj_en  in  1  adjust mode active (debounced)
- adj_sel  in  1  1 = seconds field selected, 0 = minutes field selected
- mt, mo, st, so  in  4 each  BCD digits: minutes tens, minutes ones, seconds tens, seconds ones
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- an  out  4  active-low anode enables, one-hot when showing
- dp  out  1  active-low decimal point
- frame_done  out  1  one-cycle pulse when the scan wraps from idx 3 to idx 0

Behaviour:
- Reset (rst_n=0 at posedge), overriding all other activity including mid-show:
  - state=BLANK, blank counter=0, idx=3, blink_phase=0, snapshot=0.
  - an=1111, seg=1111111, dp=1, frame_done=0.
- FSM states:
  - BLANK: an=1111, seg=1111111, dp=1. Counter increments each cycle. On the edge where counter==BLANK_CYCLES-1: state becomes SHOW, idx becomes idx+1 mod 4, counter clears. scan_tick is ignored in BLANK.
  - SHOW: holds outputs until scan_tick=1, then next edge enters BLANK.
- Registered outputs: an, seg and dp take their SHOW values on the same edge that enters SHOW.
- Timing from reset release: BLANK for exactly BLANK_CYCLES cycles, then idx0 is shown.
- Digit map:
  - idx0 = so, an=1110
  - idx1 = st, an=1101
  - idx2 = mo, an=1011
  - idx3 = mt, an=0111
- Frame snapshot: on the edge entering SHOW idx0, snapshot<={mt,mo,st,so}. idx0 decodes the live so; idx1..3 decode the snapshot.
- frame_done: high for exactly one cycle, coincident with entering SHOW idx0. It does not fire on the first idx0 after reset.
- Decode (seg, active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10..15 = 0111111 (dash).
- dp=0 only while in SHOW with idx==DP_DIGIT; otherwise 1.
- Blink:
  - blink_phase toggles on each blink_tick while adj_en=1.
  - blink_phase is forced to 0 on any cycle adj_en=0, regardless of blink_tick.
  - When adj_en=1 and blink_phase=1, the selected field's digits show seg=1111111 with an still asserted; dp is unaffected. Selected field: adj_sel=1 -> idx0, idx1; adj_sel=0 -> idx2, idx3.
  - Blanking is evaluated every cycle in SHOW, so a blink edge takes effect mid-digit on the next edge.
- Simultaneous scan_tick and blink_tick are both honoured. The toggled phase never reaches the digit being left.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: when the snapshot mt==0, idx3's SHOW period drives an=1111, seg=1111111 and frame timing is unchanged.
- Undefined: mt==0 is displayed as 0 (seg=1000000, an=0111).

Test Plan:
- Reset: assert rst_n=0 for 3 cycles while idx1 is shown -> an=1111, seg=1111111, dp=1, frame_done=0 from the first reset edge. After release, exactly BLANK_CYCLES cycles dark, then an=1110.
- Scan, with BLANK_CYCLES=2, digits mt,mo,st,so=1,2,3,4:
  - Shows idx0 an=1110 seg=0011001, then idx1 an=1101 seg=0110000, then idx2 an=1011 seg=0100100 dp=0, then idx3 an=0111 seg=1111001.
  - Each digit follows a scan_tick plus 2 dark cycles.
  - frame_done pulses once on return to idx0.
- Anti-tear: change mt 1->5 while idx0 is shown -> idx3 this frame still shows 1111001; the next frame's idx3 shows 0010010.
- Blink: adj_en=1, adj_sel=1, one blink_tick -> idx0/idx1 seg=1111111 with an asserted, idx2/idx3 unchanged; second blink_tick restores them; adj_en=0 clears the phase.
- Invalid BCD: so=4'hC -> idx0 seg=0111111.
- Macro: mt=0 -> idx3 an=1111 with SEG7_LEADING_ZERO_BLANK_EN defined; an=0111 seg=1000000 without it.
